// File: rtl/adc_8ch_emul.sv
// Serial slave emulating the 8-channel muxed ADC: decodes channel-select commands on DIN and returns samples on DOUT.
// Build option: define ADC_EMUL_PATTERN_EN to return {CHANNEL, frame counter} instead of SAMPLE_BUS data.
module adc_8ch_emul #(
    parameter int DATA_W     = 12,
    parameter int LEAD_ZEROS = 4,
    parameter int IDLE_TO    = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                SCLK,
    input  logic                CS_ADC,
    input  logic                CD_MUX,
    input  logic                DIN,
    output logic                DOUT,
    input  logic [8*DATA_W-1:0] SAMPLE_BUS,
    output logic [2:0]          CHANNEL,
    output logic                CMD_STB,
    output logic                DATA_STB,
    output logic                FRAME_ERR,
    output logic                BUSY
);
    localparam int TOTAL = LEAD_ZEROS + DATA_W;
    localparam int TO_W  = $clog2(IDLE_TO + 1);

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    state_t            state_reg;
    logic [2:0]        sclk_sync_reg;
    logic [2:0]        cdm_sync_reg;
    logic [1:0]        din_sync_reg;
    logic [4:0]        bit_cnt_reg;
    logic [TO_W-1:0]   to_cnt_reg;
    logic              start_seen_reg;
    logic [2:0]        cmd_ch_reg;
    logic [TOTAL-1:0]  shift_reg;

    logic              sclk_rise, cdm_edge, cdm_rise, cdm_fall, din_s, cdm_s;
    logic              timeout, frame_end, frame_open, cmd_ok, data_done;
    logic [2:0]        eff_channel;
    logic [DATA_W-1:0] word_data;
    logic [TOTAL-1:0]  word_full;

    // CS_ADC is only monitored by the controller side; nothing here depends on it.
    logic unused_cs;
    assign unused_cs = CS_ADC;

    assign sclk_rise = sclk_sync_reg[1] & ~sclk_sync_reg[2];
    assign cdm_edge  = cdm_sync_reg[1] ^ cdm_sync_reg[2];
    assign cdm_rise  = cdm_edge & cdm_sync_reg[1];
    assign cdm_fall  = cdm_edge & ~cdm_sync_reg[1];
    assign cdm_s     = cdm_sync_reg[1];
    assign din_s     = din_sync_reg[1];

    assign timeout    = !sclk_rise && (to_cnt_reg == TO_W'(IDLE_TO - 1));
    assign frame_end  = ((state_reg == CMD)  && (cdm_fall || timeout)) ||
                        ((state_reg == DATA) && (cdm_rise || timeout));
    assign frame_open = sclk_rise && ((state_reg == IDLE) || frame_end);
    assign cmd_ok     = start_seen_reg && (bit_cnt_reg == 5'd3);
    assign data_done  = (bit_cnt_reg == 5'(TOTAL));

    // A command closing on the same edge that opens a data frame already selects the new channel.
    assign eff_channel = ((state_reg == CMD) && frame_end && cmd_ok) ? cmd_ch_reg : CHANNEL;

`ifdef ADC_EMUL_PATTERN_EN
    localparam int FC_W = DATA_W - 3;
    logic [FC_W-1:0] frame_cnt_reg;
    logic            unused_bus;

    assign unused_bus = ^SAMPLE_BUS;
    assign word_data  = {eff_channel, frame_cnt_reg};

    always_ff @(posedge clk) begin
        if (rst)
            frame_cnt_reg <= '0;
        else if (frame_end && (state_reg == DATA) && data_done)
            frame_cnt_reg <= frame_cnt_reg + FC_W'(1);
    end
`else
    logic [DATA_W-1:0] sample_arr [8];

    for (genvar gi = 0; gi < 8; gi++) begin : g_slice
        assign sample_arr[gi] = SAMPLE_BUS[gi*DATA_W +: DATA_W];
    end

    assign word_data = sample_arr[eff_channel];
`endif

    assign word_full = TOTAL'(word_data);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            sclk_sync_reg  <= '0;
            cdm_sync_reg   <= '0;
            din_sync_reg   <= '0;
            bit_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            start_seen_reg <= 1'b0;
            cmd_ch_reg     <= '0;
            shift_reg      <= '0;
            DOUT           <= 1'b0;
            CHANNEL        <= '0;
            CMD_STB        <= 1'b0;
            DATA_STB       <= 1'b0;
            FRAME_ERR      <= 1'b0;
            BUSY           <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[1:0], SCLK};
            cdm_sync_reg  <= {cdm_sync_reg[1:0], CD_MUX};
            din_sync_reg  <= {din_sync_reg[0], DIN};
            CMD_STB       <= 1'b0;
            DATA_STB      <= 1'b0;
            FRAME_ERR     <= 1'b0;

            if ((state_reg == IDLE) || sclk_rise)
                to_cnt_reg <= '0;
            else if (to_cnt_reg != TO_W'(IDLE_TO))
                to_cnt_reg <= to_cnt_reg + TO_W'(1);

            // Close the running frame first; a coincident edge may reopen one below.
            if (frame_end) begin
                if (state_reg == CMD) begin
                    if (cmd_ok) begin
                        CHANNEL <= cmd_ch_reg;
                        CMD_STB <= 1'b1;
                    end else begin
                        FRAME_ERR <= 1'b1;
                    end
                end else begin
                    if (data_done)
                        DATA_STB <= 1'b1;
                    else
                        FRAME_ERR <= 1'b1;
                end
                state_reg <= IDLE;
                BUSY      <= 1'b0;
                DOUT      <= 1'b0;
            end

            if (frame_open) begin
                BUSY <= 1'b1;
                if (cdm_s) begin
                    state_reg      <= CMD;
                    start_seen_reg <= din_s;
                    bit_cnt_reg    <= '0;
                    cmd_ch_reg     <= '0;
                    DOUT           <= 1'b0;
                end else begin
                    state_reg   <= DATA;
                    DOUT        <= word_full[TOTAL-1];
                    shift_reg   <= word_full << 1;
                    bit_cnt_reg <= 5'd1;
                end
            end else if (sclk_rise && !frame_end) begin
                case (state_reg)
                    CMD: begin
                        if (!start_seen_reg) begin
                            start_seen_reg <= din_s;
                        end else if (bit_cnt_reg < 5'd3) begin
                            cmd_ch_reg  <= {cmd_ch_reg[1:0], din_s};
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                        end
                    end
                    DATA: begin
                        DOUT      <= shift_reg[TOTAL-1];
                        shift_reg <= shift_reg << 1;
                        if (!data_done)
                            bit_cnt_reg <= bit_cnt_reg + 5'd1;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/adc_8ch_emul.md
# adc_8ch_emul

Synthesizable emulator of the 8-channel ADC with input multiplexer, i.e. the serial slave that answers the `adc_8ch_045` controller. It decodes channel-select command frames on `DIN` (`CS_ADC`/`CD_MUX` high) and returns a 12-bit sample for the selected channel on `DOUT` during data frames. It is used for board-level loopback and FPGA self-test in place of the real converter. All serial inputs are oversampled in the single `clk` domain; `clk` must be at least 8× the `SCLK` frequency.

## Interface
- `DATA_W`, 12: sample width in bits.
- `LEAD_ZEROS`, 4: number of zero bits shifted out before the sample MSB in each data frame.
- `IDLE_TO`, 64: frame-end timeout, in `clk` cycles without an `SCLK` rising edge.

- `clk`  in  1  system clock. One clock domain only.
- `rst`  in  1  synchronous, active-high reset.
- `SCLK`  in  1  serial clock from the controller, asynchronous.
- `CS_ADC`  in  1  chip select from the controller, asynchronous. Monitored only.
- `CD_MUX`  in  1  command/data select: 1 = command frame, 0 = data frame. Asynchronous.
- `DIN`  in  1  command serial data, asynchronous.
- `DOUT`  out  1  sample serial data, registered.
- `SAMPLE_BUS`  in  8*DATA_W  per-channel sample values; channel n occupies bits `[n*DATA_W +: DATA_W]`.
- `CHANNEL`  out  3  currently selected channel.
- `CMD_STB`  out  1  one-cycle pulse when a valid command is decoded.
- `DATA_STB`  out  1  one-cycle pulse when a complete data word has been sent.
- `FRAME_ERR`  out  1  one-cycle pulse when a frame is malformed or truncated.
- `BUSY`  out  1  high while a frame is in progress.

## Operation
- **Input conditioning**
  - `SCLK`, `CD_MUX` and `DIN` pass through a 2-flop synchronizer.
  - A third flop on `SCLK` produces `sclk_rise` and on `CD_MUX` produces `cdm_edge`.
- **FSM states: IDLE, CMD, DATA.**
- **IDLE**
  - `DOUT` = 0.
  - On `sclk_rise` with synchronized `CD_MUX`=1: go to CMD and process that edge as the first command bit.
  - On `sclk_rise` with synchronized `CD_MUX`=0: go to DATA and process that edge as the first data edge.
- **CMD**
  - Each `sclk_rise` samples `DIN`.
  - Leading zeros are skipped until the first 1 (the start bit) is seen.
  - The next 3 bits are the channel number, MSB first.
  - Bits after that are ignored.
  - The frame ends on a `CD_MUX` falling edge or on the `IDLE_TO` timeout.
  - If the start bit and all 3 channel bits were captured: `CHANNEL` is updated and `CMD_STB` pulses.
  - Otherwise `FRAME_ERR` pulses and `CHANNEL` is unchanged.
  - Then go to IDLE.
- **DATA**
  - On the entry edge, the word `{LEAD_ZEROS×0, SAMPLE_BUS slice[CHANNEL]}` is latched.
  - The word's first bit is driven on `DOUT` on that same edge.
  - Each further `sclk_rise` advances one bit, MSB first.
  - After `LEAD_ZEROS+DATA_W` bits, `DOUT` = 0 for any extra edges.
  - The frame ends on a `CD_MUX` rising edge or on the timeout.
  - If all bits were sent: `DATA_STB` pulses.
  - Otherwise `FRAME_ERR` pulses.
  - Then go to IDLE.
- **Simultaneous frame end and `sclk_rise` in the same cycle**
  - The current frame closes first.
  - The same edge then starts the new frame, with its type taken from the new `CD_MUX` level.
- **Counters**
  - Bit counter is 5 bits and saturates at `LEAD_ZEROS+DATA_W`.
  - Timeout counter is cleared on every `sclk_rise` and saturates at `IDLE_TO`.
- **Reset values:** `DOUT`=0, `CHANNEL`=0, `CMD_STB`=0, `DATA_STB`=0, `FRAME_ERR`=0, `BUSY`=0; FSM in IDLE.
- **Reset mid-frame** abandons the frame with no strobe. The next frame starts at the first `sclk_rise` after `rst` is deasserted.

## Timing
- Latency from a pin `SCLK` rise to `sclk_rise` is 3 `clk` cycles.
- `DOUT` changes on the `clk` edge after `sclk_rise`, i.e. 3–4 `clk` cycles after the pin edge. This is below half an `SCLK` period at the 8× ratio, so the controller's `SCLK`-falling capture is met.
- `DIN` is sampled on the same `clk` cycle as `sclk_rise`, through the same synchronizer depth as `SCLK`.
- `CMD_STB`, `DATA_STB` and `FRAME_ERR` are high exactly one `clk` cycle, one cycle after the frame end is detected.
- `CHANNEL` updates in the same cycle as `CMD_STB`.
- `BUSY` rises on the cycle after the first `sclk_rise`. It falls together with the end-of-frame strobe.
- Timeout fires on the `IDLE_TO`-th consecutive cycle without `sclk_rise`.

## Configuration
- **`ADC_EMUL_PATTERN_EN` defined**
  - `SAMPLE_BUS` is ignored.
  - The data word is `{CHANNEL, frame_cnt[DATA_W-4:0]}`.
  - `frame_cnt` increments on each `DATA_STB` and wraps; it is reset to 0.
- **`ADC_EMUL_PATTERN_EN` not defined:** samples come from `SAMPLE_BUS` as described above.

## Test plan
- Command frame, `DIN` = 0,0,0,1,1,0,1,0 over 8 `SCLK` pulses, then `CD_MUX` falls -> `CHANNEL`=5 and a single-cycle `CMD_STB`.
- `CHANNEL`=5, slice 5 = 0xA5C, 17-pulse data frame -> `DOUT` sequence 0000_1010_0101_1100_0 sampled at `SCLK` falling; `DATA_STB` after `CD_MUX` rises.
- Command frame with all `DIN`=0 -> `FRAME_ERR` pulse, `CHANNEL` unchanged, no `CMD_STB`.
- Data frame stopped after 6 `SCLK` pulses -> `FRAME_ERR` 64 cycles after the last edge, no `DATA_STB`, `BUSY` falls.
- `rst` during bit 8 of a data frame -> next cycle `DOUT`=0, `CHANNEL`=0, `BUSY`=0; a following command for channel 3 decodes correctly.
- `ADC_EMUL_PATTERN_EN` defined, 8 channels × 2 sweeps from the controller -> words 0x000, 0x201, … 0xE07, then 0x008 … 0xE0F.
